// File: rtl/arch_rat_pkg.sv
// Shared types and width helpers for the committed register alias table and its slot resolver.
package arch_rat_pkg;

    localparam int ARF_DEPTH_DEF = 32;
    localparam int PRF_DEPTH_DEF = 64;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int arf_w(input int arf_depth);
        return idx_w(arf_depth);
    endfunction

    function automatic int prf_w(input int prf_depth);
        return idx_w(prf_depth);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } rat_state_e;

    typedef struct packed {
        logic                              valid;
        logic [arf_w(ARF_DEPTH_DEF)-1:0]   arn;
        logic [prf_w(PRF_DEPTH_DEF)-1:0]   prn;
    } retire_slot_t;

endpackage

// File: rtl/arch_rat_group_resolve.sv
// Combinational resolution of one retire group: write enables, youngest-writer mask per arn,
// and the stale prn each slot displaces (an older same-arn slot in the group shadows the map).
module arch_rat_group_resolve
#(
    parameter int RETIRE_WIDTH = 4,
    parameter int ARF_W        = 5,
    parameter int PRF_W        = 6
)(
    input  logic [RETIRE_WIDTH-1:0]       retire_valid,
    input  logic                          accept,
    input  logic [RETIRE_WIDTH*ARF_W-1:0] arn,
    input  logic [RETIRE_WIDTH*PRF_W-1:0] prn,
    input  logic [RETIRE_WIDTH*PRF_W-1:0] map_prn,
    output logic [RETIRE_WIDTH-1:0]       we,
    output logic [RETIRE_WIDTH-1:0]       win,
    output logic [RETIRE_WIDTH*PRF_W-1:0] stale
);

    always_comb begin
        we    = '0;
        win   = '0;
        stale = map_prn;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            we[k] = retire_valid[k] && accept && (arn[k*ARF_W +: ARF_W] != '0);
        end
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            win[k] = we[k];
            for (int j = 0; j < RETIRE_WIDTH; j++) begin
                if (we[j] && (arn[j*ARF_W +: ARF_W] == arn[k*ARF_W +: ARF_W])) begin
                    // ascending j: the last older match is the closest one
                    if (j < k) stale[k*PRF_W +: PRF_W] = prn[j*PRF_W +: PRF_W];
                    if (j > k) win[k] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/arch_rat_ckpt.sv
// Committed arn->prn map: retire updates, stale-prn release, and beat-wise flush copy-out.
// Optional macro ARCH_RAT_BYPASS_EN forwards same-cycle retire writes onto arch_rat_out.
module arch_rat_ckpt
    import arch_rat_pkg::*;
#(
    parameter  int ARF_DEPTH    = 32,
    parameter  int PRF_DEPTH    = 64,
    parameter  int RETIRE_WIDTH = 4,
    parameter  int COPY_PORTS   = 8,
    localparam int ARF_W        = arf_w(ARF_DEPTH),
    localparam int PRF_W        = prf_w(PRF_DEPTH)
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [RETIRE_WIDTH-1:0]       retire_valid,
    input  logic [RETIRE_WIDTH*ARF_W-1:0] retire_dest_arn,
    input  logic [RETIRE_WIDTH*PRF_W-1:0] retire_dest_prn,
    output logic                          retire_ready,
    output logic [RETIRE_WIDTH-1:0]       free_valid,
    output logic [RETIRE_WIDTH*PRF_W-1:0] free_prn,
    input  logic                          recover_req,
    output logic                          recover_valid,
    output logic [ARF_W-1:0]              recover_base,
    output logic [COPY_PORTS*PRF_W-1:0]   recover_prn,
    output logic                          recover_done,
    output logic [ARF_DEPTH*PRF_W-1:0]    arch_rat_out
);

    localparam int NBEATS = ARF_DEPTH / COPY_PORTS;
    localparam int BEAT_W = idx_w(NBEATS);

    rat_state_e                    state_q, state_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic [PRF_W-1:0]              map_q [ARF_DEPTH];
    logic [PRF_W-1:0]              map_d [ARF_DEPTH];
    logic [RETIRE_WIDTH*PRF_W-1:0] map_rd;
    logic [RETIRE_WIDTH-1:0]       we, win;
    logic [RETIRE_WIDTH*PRF_W-1:0] stale;
    logic [RETIRE_WIDTH*PRF_W-1:0] free_prn_d;
    logic [ARF_W-1:0]              rec_base_d;
    logic [COPY_PORTS*PRF_W-1:0]   rec_prn_d;

    always_comb begin
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            map_rd[k*PRF_W +: PRF_W] = map_q[retire_dest_arn[k*ARF_W +: ARF_W]];
        end
    end

    arch_rat_group_resolve #(
        .RETIRE_WIDTH (RETIRE_WIDTH),
        .ARF_W        (ARF_W),
        .PRF_W        (PRF_W)
    ) u_resolve (
        .retire_valid (retire_valid),
        .accept       (retire_ready),
        .arn          (retire_dest_arn),
        .prn          (retire_dest_prn),
        .map_prn      (map_rd),
        .we           (we),
        .win          (win),
        .stale        (stale)
    );

    always_comb begin
        map_d      = map_q;
        free_prn_d = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (win[k]) map_d[retire_dest_arn[k*ARF_W +: ARF_W]] = retire_dest_prn[k*PRF_W +: PRF_W];
            if (we[k])  free_prn_d[k*PRF_W +: PRF_W] = stale[k*PRF_W +: PRF_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        retire_ready = 1'b0;
        case (state_q)
            IDLE: begin
                retire_ready = 1'b1;
                if (recover_req) begin
                    state_d = WALK;
                    beat_d  = '0;
                end
            end
            WALK: begin
                if (beat_q == BEAT_W'(NBEATS - 1)) state_d = DONE;
                else                               beat_d  = beat_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                beat_d  = '0;
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Beat outputs are loaded from map_d so a retire in the request cycle lands in beat 0.
    always_comb begin
        rec_base_d = '0;
        rec_prn_d  = '0;
        if (state_d == WALK) begin
            rec_base_d = ARF_W'(int'(beat_d) * COPY_PORTS);
            for (int c = 0; c < COPY_PORTS; c++) begin
                rec_prn_d[c*PRF_W +: PRF_W] = map_d[rec_base_d + ARF_W'(c)];
            end
        end
    end

    // Stage p1: committed map, released prns and recovery beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARF_DEPTH; i++) map_q[i] <= PRF_W'(i);
            free_valid    <= '0;
            free_prn      <= '0;
            recover_valid <= 1'b0;
            recover_base  <= '0;
            recover_prn   <= '0;
            recover_done  <= 1'b0;
        end else begin
            map_q         <= map_d;
            free_valid    <= we;
            free_prn      <= free_prn_d;
            recover_valid <= (state_d == WALK);
            recover_base  <= rec_base_d;
            recover_prn   <= rec_prn_d;
            recover_done  <= (state_d == DONE);
        end
    end

    for (genvar i = 0; i < ARF_DEPTH; i++) begin : g_out
`ifdef ARCH_RAT_BYPASS_EN
        assign arch_rat_out[i*PRF_W +: PRF_W] = map_d[i];
`else
        assign arch_rat_out[i*PRF_W +: PRF_W] = map_q[i];
`endif
    end

    a_no_retire_when_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !((|retire_valid) && !retire_ready));

endmodule
